// File: rtl/noc_link_rx_axis.sv
// noc_link_rx_axis
//   Far end of a credit-based NoC router link. Incoming flits
//   {data, dest, is_tail} are written into a small FIFO. The FIFO head is
//   presented show-ahead as an AXI-Stream master. One credit pulse is
//   returned to the upstream sender for every flit accepted downstream.
//
// Ports
//   clk_noc, rst_noc      : single clock, asynchronous active-high reset
//   data_in/dest_in/
//   is_tail_in/send_in    : router-side flit input; send_in qualifies, no back-pressure
//   credit_out            : registered one-cycle pulse per popped flit
//   axis_out_*            : AXI-Stream master (tid/tdest split from the stored dest)
//   occupancy             : flits currently buffered
//   overflow_err          : sticky; a flit arrived with no free slot and was dropped
//   pkt_count             : number of tails delivered, wraps at 2^16
module noc_link_rx_axis #(
    parameter int FLIT_WIDTH        = 128,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 2,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [FLIT_WIDTH-1:0]  axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic [CNT_WIDTH-1:0]   occupancy,
    output logic                   overflow_err,
    output logic [15:0]            pkt_count
);

    localparam int PTR_W   = $clog2(FLIT_BUFFER_DEPTH);
    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

    // Entry layout: {data, dest, is_tail}
    logic [ENTRY_W-1:0] mem [FLIT_BUFFER_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [ENTRY_W-1:0]    head;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  head_tail;
    logic                  is_full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Stage p0: head decode and push/pop arbitration (combinational)
    assign head      = mem[rd_ptr];
    assign head_tail = head[0];
    assign head_dest = head[DEST_WIDTH:1];

    assign axis_out_tvalid = (occupancy != '0);
    assign axis_out_tdata  = head[ENTRY_W-1:DEST_WIDTH+1];
    assign axis_out_tlast  = head_tail;
    assign axis_out_tid    = head_dest[DEST_WIDTH-1:TDEST_WIDTH];
    assign axis_out_tdest  = head_dest[TDEST_WIDTH-1:0];

    assign is_full = (occupancy == FULL_CNT);
    assign pop     = axis_out_tvalid && axis_out_tready;
    // A full FIFO still accepts a flit when the head leaves in the same
    // cycle: the freed slot is the one being written.
    assign push    = send_in && (!is_full || pop);
    assign drop    = send_in && is_full && !pop;

    // Stage p1: storage (data only, no reset; contents are don't-care
    // while occupancy is zero)
    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
        end
    end

    // Stage p1: control state
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            credit_out   <= 1'b0;
            overflow_err <= 1'b0;
            pkt_count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - CNT_WIDTH'(1);
            end
            // Credit follows consumption, so a dropped flit never earns one.
            credit_out <= pop;
            if (drop) begin
                overflow_err <= 1'b1;
            end
            if (pop && head_tail) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_rx_axis.sv
module tb_noc_link_rx_axis;

    localparam int FW    = 128;
    localparam int DEPTH = 4;

    typedef struct {
        logic [FW-1:0] data;
        logic [3:0]    dest;
        logic          tail;
    } flit_t;

    logic          clk_noc = 1'b0;
    logic          rst_noc;
    logic [FW-1:0] data_in;
    logic [3:0]    dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic [FW-1:0] axis_out_tdata;
    logic          axis_out_tlast;
    logic [1:0]    axis_out_tid;
    logic [1:0]    axis_out_tdest;
    logic [2:0]    occupancy;
    logic          overflow_err;
    logic [15:0]   pkt_count;

    noc_link_rx_axis dut (
        .clk_noc         (clk_noc),
        .rst_noc         (rst_noc),
        .data_in         (data_in),
        .dest_in         (dest_in),
        .is_tail_in      (is_tail_in),
        .send_in         (send_in),
        .credit_out      (credit_out),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tid    (axis_out_tid),
        .axis_out_tdest  (axis_out_tdest),
        .occupancy       (occupancy),
        .overflow_err    (overflow_err),
        .pkt_count       (pkt_count)
    );

    always #5 clk_noc = ~clk_noc;

    int    n_checks = 0;
    int    n_fail   = 0;
    flit_t sb[$];
    int    m_occ    = 0;
    logic  m_ovf    = 1'b0;
    int    m_pkt    = 0;
    int    credits_seen = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [FW-1:0] d, input logic [3:0] ds, input logic t);
        send_in    = s;
        data_in    = d;
        dest_in    = ds;
        is_tail_in = t;
    endtask

    // One clock: compare any popping head against the scoreboard, update the
    // reference model, advance past the edge and check registered state.
    task automatic tick();
        bit    popping;
        bit    pushing;
        flit_t e;
        flit_t n;
        popping = (m_occ != 0) && (axis_out_tready === 1'b1);
        chk("tvalid", axis_out_tvalid, (m_occ != 0));
        if (popping) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("tdata", axis_out_tdata, e.data);
                chk("tid",   axis_out_tid,   e.dest[3:2]);
                chk("tdest", axis_out_tdest, e.dest[1:0]);
                chk("tlast", axis_out_tlast, e.tail);
                if (e.tail) m_pkt++;
            end
        end
        pushing = send_in && ((m_occ < DEPTH) || popping);
        if (send_in && (m_occ == DEPTH) && !popping) m_ovf = 1'b1;
        if (pushing) begin
            n.data = data_in;
            n.dest = dest_in;
            n.tail = is_tail_in;
            sb.push_back(n);
        end
        if (pushing && !popping) m_occ++;
        else if (popping && !pushing) m_occ--;
        @(posedge clk_noc);
        #1;
        chk("credit", credit_out, popping);
        if (credit_out === 1'b1) credits_seen++;
        chk("occupancy", occupancy, m_occ);
        chk("overflow", overflow_err, m_ovf);
        chk("pkt_count", pkt_count, m_pkt);
    endtask

    logic [FW-1:0] dv [5];
    logic [FW-1:0] d0;
    int            sent;
    int            up_cred;
    int            cred_base;
    int            cyc;
    logic [3:0]    rdest;

    initial begin
        rst_noc         = 1'b1;
        axis_out_tready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) dv[i] = {$urandom, $urandom, $urandom, $urandom};

        // Reset values
        repeat (3) @(posedge clk_noc);
        #1;
        chk("rst_tvalid", axis_out_tvalid, 1'b0);
        chk("rst_credit", credit_out, 1'b0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ovf", overflow_err, 1'b0);
        chk("rst_pkt", pkt_count, 0);
        rst_noc = 1'b0;
        tick();

        // Single-flit packet
        drive(1'b1, {16{8'hA5}}, 4'b1001, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("single_tvalid", axis_out_tvalid, 1'b1);
        chk("single_tid", axis_out_tid, 2'b10);
        chk("single_tdest", axis_out_tdest, 2'b01);
        chk("single_tlast", axis_out_tlast, 1'b1);
        axis_out_tready = 1'b1;
        tick();
        chk("single_credit", credit_out, 1'b1);
        chk("single_pkt", pkt_count, 1);
        tick();
        chk("single_credit_once", credit_out, 1'b0);

        // Back-pressure fill, then simultaneous full push/pop
        axis_out_tready = 1'b0;
        d0 = dv[0];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dv[i], 4'(i), (i == 3));
            tick();
            chk("hold_d0", axis_out_tdata, d0);
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("fill_occ", occupancy, 4);
        chk("fill_hold_d0", axis_out_tdata, d0);
        axis_out_tready = 1'b1;
        drive(1'b1, dv[4], 4'b0110, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("fullpp_occ", occupancy, 4);
        chk("fullpp_ovf", overflow_err, 1'b0);
        repeat (5) tick();
        chk("fullpp_empty", axis_out_tvalid, 1'b0);
        chk("fullpp_sb", sb.size(), 0);

        // Overflow: fill with tready low and send one more
        axis_out_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dv[3 - i], 4'(i + 8), 1'b0);
            tick();
        end
        drive(1'b1, {16{8'hEE}}, 4'b1111, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("ovf_flag", overflow_err, 1'b1);
        chk("ovf_occ", occupancy, 4);
        axis_out_tready = 1'b1;
        repeat (5) tick();
        chk("ovf_sticky", overflow_err, 1'b1);
        chk("ovf_drained", axis_out_tvalid, 1'b0);

        // Reset mid-stream with 3 flits buffered and a credit in flight
        axis_out_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dv[i], 4'(i), 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        axis_out_tready = 1'b1;
        tick();
        axis_out_tready = 1'b0;
        chk("pre_rst_credit", credit_out, 1'b1);
        chk("pre_rst_occ", occupancy, 3);
        rst_noc = 1'b1;
        #1;
        chk("midrst_tvalid", axis_out_tvalid, 1'b0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_credit", credit_out, 1'b0);
        sb.delete();
        m_occ = 0;
        m_ovf = 1'b0;
        m_pkt = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_noc);
            #1;
            chk("rst_no_credit", credit_out, 1'b0);
        end
        rst_noc = 1'b0;
        tick();
        drive(1'b1, dv[2], 4'b0011, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("postrst_latency", axis_out_tvalid, 1'b1);
        axis_out_tready = 1'b1;
        tick();
        tick();

        // Wrap-around streaming with credit-honouring upstream
        sent      = 0;
        up_cred   = DEPTH;
        cred_base = credits_seen;
        cyc       = 0;
        while ((sent < 37 || sb.size() != 0) && cyc < 2000) begin
            axis_out_tready = 1'($urandom_range(0, 1));
            if (sent < 37 && up_cred > 0) begin
                rdest = 4'($urandom);
                drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, rdest, 1'($urandom_range(0, 1)));
                up_cred--;
                sent++;
            end else begin
                drive(1'b0, '0, '0, 1'b0);
            end
            tick();
            if (credit_out === 1'b1) up_cred++;
            cyc++;
        end
        drive(1'b0, '0, '0, 1'b0);
        chk("stream_done", (cyc < 2000), 1'b1);
        chk("stream_credits", credits_seen - cred_base, 37);
        chk("stream_upcred", up_cred, DEPTH);
        chk("stream_ovf", overflow_err, 1'b0);
        chk("stream_pkt", pkt_count, m_pkt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_link_rx_axis.md
# noc_link_rx_axis

Credit-based NoC link receiver that terminates one router output port (data/dest/is_tail/send, credit return) and presents the flits as an AXI-Stream master. Incoming flits are buffered in a FLIT_BUFFER_DEPTH FIFO, and one credit is returned per flit consumed downstream. It sits at a mesh edge or test harness as the far end of a router-to-router link, and mirrors the router's input-port buffering and credit contract.

## Interface
Parameters:
- FLIT_WIDTH, 128: flit payload width; equals axis_out_tdata width.
- TID_WIDTH, 2: width of the TID field in dest.
- TDEST_WIDTH, 2: width of the TDEST field in dest.
- DEST_WIDTH, TDEST_WIDTH + TID_WIDTH: dest field width, packed {tid, tdest}.
- FLIT_BUFFER_DEPTH, 4: FIFO depth. Must be a power of 2 and ≥2. Must equal the credit count the upstream sender is initialised with.
- CNT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1): width of the occupancy output.

Ports:
- clk_noc, in, 1: the single clock.
- rst_noc, in, 1: asynchronous, active-high reset.
- data_in, in, FLIT_WIDTH: flit payload, qualified by send_in.
- dest_in, in, DEST_WIDTH: flit destination {tid, tdest}.
- is_tail_in, in, 1: last flit of the packet.
- send_in, in, 1: flit valid; one flit per asserted cycle, with no back-pressure.
- credit_out, out, 1: one-cycle pulse, one buffer slot freed.
- axis_out_tvalid, out, 1: AXI-Stream valid.
- axis_out_tready, in, 1: AXI-Stream ready.
- axis_out_tdata, out, FLIT_WIDTH: AXI-Stream data.
- axis_out_tlast, out, 1: AXI-Stream last; equals the stored is_tail.
- axis_out_tid, out, TID_WIDTH: dest[DEST_WIDTH-1:TDEST_WIDTH].
- axis_out_tdest, out, TDEST_WIDTH: dest[TDEST_WIDTH-1:0].
- occupancy, out, CNT_WIDTH: number of flits currently buffered.
- overflow_err, out, 1: sticky flag, a flit arrived with no free slot.
- pkt_count, out, 16: count of tails delivered; wraps at 2^16.

## Operation
- **Storage:** FIFO of {data, dest, is_tail}.
  - Write and read pointers are $clog2(FLIT_BUFFER_DEPTH) bits wide and wrap naturally.
  - A separate occupancy counter distinguishes full from empty.
- **Push:** occurs when send_in=1 and either occupancy<FLIT_BUFFER_DEPTH or a pop happens in the same cycle.
- **Pop:** occurs when axis_out_tvalid=1 and axis_out_tready=1.
- **Head output:** the FIFO head is shown directly on the AXI-Stream outputs (show-ahead).
  - axis_out_tvalid = (occupancy≠0).
  - tdata, tlast, tid and tdest remain stable while tvalid=1 and tready=0.
- **Occupancy update:**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, both pointers advance.
- **Overflow:**
  - Condition: send_in=1, occupancy==FLIT_BUFFER_DEPTH and no pop in that cycle.
  - The flit is dropped.
  - FIFO contents and pointers are unchanged.
  - overflow_err sets and stays set until reset.
  - No credit is generated for the dropped flit.
- **Credits:** credit_out is registered and equals the pop of the previous cycle. Exactly one pulse per popped flit, never more.
- **Packet count:** pkt_count increments on each pop with tlast=1.
- **No packet parsing:** dest is passed through per flit, and interleaving is the upstream's responsibility.

## Timing
- **Reset values:**
  - axis_out_tvalid=0, credit_out=0, occupancy=0, overflow_err=0, pkt_count=0.
  - Pointers are 0.
  - tdata, tlast, tid and tdest are don't-care while tvalid=0; the implementation drives 0 from the reset-cleared RAM output register, or drives any value if the RAM is unreset.
- **Reset mid-operation:** all buffered flits are flushed with no credits returned. The upstream is reset in the same domain and restores its full credit count.
- **Latency:**
  - A flit sampled with send_in at edge N appears with axis_out_tvalid=1 in cycle N+1, even when the FIFO was empty. There is no bypass path.
  - A pop at edge N produces credit_out=1 during cycle N+1.
- **Throughput:** with tready held at 1 and a steady stream of sends, the block sustains 1 flit per cycle, and occupancy settles at 1.
- **Round trip:** from pop to credit pulse is 1 cycle. With upstream credit-counter latency L, FLIT_BUFFER_DEPTH ≥ L+2 is required for full rate. That condition is a system constraint, not checked here.
- **Full + pop + send in one cycle:** the push is accepted, there is no overflow, and occupancy stays at FLIT_BUFFER_DEPTH.

## Test plan
- **Single-flit packet:** after reset, send one flit with data=0xA5…A5, dest=4'b1001, tail=1.
  - Next cycle: tvalid=1, tid=2'b10, tdest=2'b01, tlast=1.
  - With tready=1, the flit pops.
  - credit_out pulses once in the following cycle, and pkt_count=1.
- **Back-pressure fill:** hold tready=0 and send 4 flits (D0..D3).
  - occupancy=4 and tdata=D0, stable throughout.
  - Then set tready=1: D0..D3 are delivered in order on consecutive cycles, with 4 credit pulses each lagging its pop by 1 cycle.
- **Overflow:** with the FIFO full and tready=0, send a fifth flit.
  - overflow_err=1, occupancy stays 4, and the dropped flit never appears.
  - overflow_err stays 1 after the FIFO drains.
- **Simultaneous full push/pop:** with the FIFO full, assert tready=1 and send_in=1 in the same cycle.
  - occupancy stays 4 and overflow_err stays 0.
  - The new flit is delivered 5th in order.
- **Wrap-around streaming:** send 37 flits with random tready (50%) while the bench model honours credits.
  - All 37 flits are delivered in order, with 37 credits total and overflow_err=0.
  - pkt_count matches the number of tails.
- **Reset mid-stream:** assert rst_noc with 3 flits buffered.
  - tvalid, occupancy and credit_out go to 0 immediately, with no credit pulses.
  - After release, the first new flit arrives with 1-cycle latency.
